// File: rtl/fb_arbiter_if.sv
// Bundle between fb_arbiter, its two requesters (LCD scan-out, renderer) and the framebuffer BRAM.
// The master side drives requests and RAM read data; the slave side is the arbiter itself.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              swap_req;
  logic              swap_ack;
  logic              front_bank;
  logic              vsync;

  logic [ADDR_W:0]   ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, swap_req, vsync, ram_rdata,
    input  disp_data, disp_valid, wr_ready, swap_ack, front_bank, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, swap_req, vsync, ram_rdata,
    output disp_data, disp_valid, wr_ready, swap_ack, front_bank, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads the front bank with absolute priority,
// renderer writes the back bank, banks swap on vsync after a request, optional back-bank clear.
module fb_arbiter #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 4,
  parameter int                FB_WORDS    = 384000,
  parameter bit                CLEAR_EN    = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input logic         i_pixel_clock,
  input logic         i_pixel_reset,
  fb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_WORDS - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_frontBank;
  logic              w_frontBankNext;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cntNext;
  logic              r_swapAck;
  logic              w_swapAckNext;
  logic              r_vsyncQ;
  logic              w_vsyncRise;
  logic              w_clearWrite;
  logic              w_wrReady;

  logic [ADDR_W:0]   r_ramAddr;
  logic              r_ramWe;
  logic [DATA_W-1:0] r_ramWdata;
  logic              r_dispReqD1;
  logic              r_dispReqD2;
  logic [DATA_W-1:0] r_dispData;
  logic              r_dispValid;

  assign w_vsyncRise = bus.vsync && !r_vsyncQ;
  assign w_wrReady   = !bus.disp_req && (r_state == IDLE);

  always_comb begin
    w_nextState     = r_state;
    w_frontBankNext = r_frontBank;
    w_cntNext       = r_cnt;
    w_swapAckNext   = 1'b0;
    w_clearWrite    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.swap_req) begin
          w_nextState = PENDING;
        end
      end
      PENDING: begin
        if (w_vsyncRise) begin
          w_frontBankNext = ~r_frontBank;
          if (CLEAR_EN) begin
            w_nextState = CLEAR;
          end else begin
            w_nextState   = IDLE;
            w_swapAckNext = 1'b1;
          end
        end
      end
      CLEAR: begin
        // Display cycles simply stall the counter, so no clear address is skipped.
        if (!bus.disp_req) begin
          w_clearWrite = 1'b1;
          if (r_cnt == LAST_PIX) begin
            w_cntNext     = '0;
            w_swapAckNext = 1'b1;
            w_nextState   = IDLE;
          end else begin
            w_cntNext = r_cnt + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_pixel_clock) begin
    if (i_pixel_reset) begin
      r_state     <= IDLE;
      r_frontBank <= 1'b0;
      r_cnt       <= '0;
      r_swapAck   <= 1'b0;
      r_vsyncQ    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_frontBank <= w_frontBankNext;
      r_cnt       <= w_cntNext;
      r_swapAck   <= w_swapAckNext;
      r_vsyncQ    <= bus.vsync;
    end
  end

  // Back-bank writes use the bank select sampled this cycle, before any toggle takes effect.
  always_ff @(posedge i_pixel_clock) begin
    if (i_pixel_reset) begin
      r_ramAddr  <= '0;
      r_ramWe    <= 1'b0;
      r_ramWdata <= '0;
    end else if (bus.disp_req) begin
      r_ramAddr <= {r_frontBank, bus.disp_addr};
      r_ramWe   <= 1'b0;
    end else if (w_clearWrite) begin
      r_ramAddr  <= {~r_frontBank, r_cnt};
      r_ramWe    <= 1'b1;
      r_ramWdata <= CLEAR_COLOR;
    end else if (bus.wr_valid && w_wrReady) begin
      r_ramAddr  <= {~r_frontBank, bus.wr_addr};
      r_ramWe    <= 1'b1;
      r_ramWdata <= bus.wr_data;
    end else begin
      r_ramWe <= 1'b0;
    end
  end

  always_ff @(posedge i_pixel_clock) begin
    if (i_pixel_reset) begin
      r_dispReqD1 <= 1'b0;
      r_dispReqD2 <= 1'b0;
      r_dispData  <= '0;
      r_dispValid <= 1'b0;
    end else begin
      r_dispReqD1 <= bus.disp_req;
      r_dispReqD2 <= r_dispReqD1;
      r_dispValid <= r_dispReqD2;
      if (r_dispReqD2) begin
        r_dispData <= bus.ram_rdata;
      end
    end
  end

  assign bus.wr_ready   = w_wrReady;
  assign bus.swap_ack   = r_swapAck;
  assign bus.front_bank = r_frontBank;
  assign bus.ram_addr   = r_ramAddr;
  assign bus.ram_we     = r_ramWe;
  assign bus.ram_wdata  = r_ramWdata;
  assign bus.disp_data  = r_dispData;
  assign bus.disp_valid = r_dispValid;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: instance A without clear (full-size banks), instance B with clear on 16-word banks.
// RAM models return a fixed function of the address with one cycle of latency.
module tb_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 4;

  typedef struct {
    logic          dispReq;
    logic [AW-1:0] dispAddr;
    logic          wrValid;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          expReady;
    logic          expWe;
    logic [AW:0]   expAddr;
    logic [DW-1:0] expWdata;
  } vec_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   passCount = 0;
  int   checkCount = 0;
  vec_t vecs[8];
  int   hits[16];

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busA ();
  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busB ();

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(384000), .CLEAR_EN(1'b0), .CLEAR_COLOR(4'h0))
    dutA (.i_pixel_clock(clk), .i_pixel_reset(rstA), .bus(busA.slave));

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(16), .CLEAR_EN(1'b1), .CLEAR_COLOR(4'h9))
    dutB (.i_pixel_clock(clk), .i_pixel_reset(rstB), .bus(busB.slave));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ramPattern(input logic [AW:0] a);
    return a[3:0] ^ a[7:4] ^ 4'hB;
  endfunction

  always @(posedge clk) begin
    busA.ram_rdata <= ramPattern(busA.ram_addr);
    busB.ram_rdata <= ramPattern(busB.ram_addr);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    busA.disp_req  = v.dispReq;
    busA.disp_addr = v.dispAddr;
    busA.wr_valid  = v.wrValid;
    busA.wr_addr   = v.wrAddr;
    busA.wr_data   = v.wrData;
    #1;
    checkOutput($sformatf("vec%0d_ready", idx), 32'(busA.wr_ready), 32'(v.expReady));
    tick();
    checkOutput($sformatf("vec%0d_ram", idx), {busA.ram_we, busA.ram_addr, busA.ram_wdata},
                {v.expWe, v.expAddr, v.expWdata});
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int writes;
    int badWrites;
    int acks;
    int ackAtWrite;
    int ackCycle;
    logic [AW:0] lastAddr;
    logic [DW-1:0] lastData;

    vecs[0] = '{1'b1, 19'h00010, 1'b1, 19'h12345, 4'h7, 1'b0, 1'b0, 20'h00010, 4'h0};
    vecs[1] = '{1'b0, 19'h00000, 1'b1, 19'h12345, 4'h7, 1'b1, 1'b1, 20'h92345, 4'h7};
    vecs[2] = '{1'b0, 19'h00000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 20'h92345, 4'h7};
    vecs[3] = '{1'b0, 19'h00000, 1'b1, 19'h7FFFF, 4'hF, 1'b1, 1'b1, 20'hFFFFF, 4'hF};
    vecs[4] = '{1'b1, 19'h5DBFF, 1'b0, 19'h00000, 4'h0, 1'b0, 1'b0, 20'h5DBFF, 4'hF};
    vecs[5] = '{1'b0, 19'h00000, 1'b1, 19'h00000, 4'h3, 1'b1, 1'b1, 20'h80000, 4'h3};
    vecs[6] = '{1'b1, 19'h7FFFF, 1'b1, 19'h00001, 4'h1, 1'b0, 1'b0, 20'h7FFFF, 4'h3};
    vecs[7] = '{1'b0, 19'h00000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 20'h7FFFF, 4'h3};

    rstA = 1'b1; rstB = 1'b1;
    busA.disp_req = 0; busA.disp_addr = '0; busA.wr_valid = 0; busA.wr_addr = '0;
    busA.wr_data = '0; busA.swap_req = 0; busA.vsync = 0;
    busB.disp_req = 0; busB.disp_addr = '0; busB.wr_valid = 0; busB.wr_addr = '0;
    busB.wr_data = '0; busB.swap_req = 0; busB.vsync = 0;
    repeat (3) tick();
    checkOutput("resetA", {busA.ram_addr, busA.ram_we, busA.ram_wdata, busA.disp_data,
                busA.disp_valid, busA.swap_ack, busA.front_bank}, 32'h0);
    checkOutput("resetB", {busB.ram_addr, busB.ram_we, busB.ram_wdata, busB.front_bank}, 32'h0);
    rstA = 1'b0; rstB = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle", {busA.ram_we, busA.front_bank, busA.wr_ready, busA.disp_valid}, 4'b0010);
    end

    // Single display read: valid exactly three cycles after the request.
    busA.disp_req = 1; busA.disp_addr = 19'h00010;
    busA.wr_valid = 1; busA.wr_addr = 19'h12345; busA.wr_data = 4'h7;
    #1 checkOutput("dispBlocksWr", 32'(busA.wr_ready), 32'd0);
    tick();
    checkOutput("dispAddr", {busA.ram_we, busA.ram_addr}, {1'b0, 20'h00010});
    busA.disp_req = 0; busA.wr_valid = 0;
    checkOutput("dispLat1", 32'(busA.disp_valid), 32'd0);
    tick();
    checkOutput("dispLat2", 32'(busA.disp_valid), 32'd0);
    tick();
    checkOutput("dispLat3", {busA.disp_valid, busA.disp_data}, {1'b1, 4'hA});
    tick();
    checkOutput("dispHold", {busA.disp_valid, busA.disp_data}, {1'b0, 4'hA});

    // Back-to-back reads keep order.
    busA.disp_req = 1; busA.disp_addr = 19'h0003C;
    tick();
    busA.disp_addr = 19'h00010;
    tick();
    busA.disp_req = 0;
    tick();
    checkOutput("b2bFirst", {busA.disp_valid, busA.disp_data}, {1'b1, 4'h4});
    tick();
    checkOutput("b2bSecond", {busA.disp_valid, busA.disp_data}, {1'b1, 4'hA});

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
    busA.disp_req = 0; busA.wr_valid = 0;
    repeat (4) tick();

    // Swap without clear: writes stall until the vsync edge.
    busA.swap_req = 1;
    tick();
    busA.swap_req = 0;
    busA.wr_valid = 1; busA.wr_addr = 19'h00020; busA.wr_data = 4'h5;
    for (int i = 0; i < 50; i++) begin
      #1 checkOutput("pendReady", 32'(busA.wr_ready), 32'd0);
      tick();
      checkOutput("pendStall", {busA.ram_we, busA.swap_ack, busA.front_bank}, 3'b000);
    end
    busA.vsync = 1;
    tick();
    checkOutput("swapEdge", {busA.front_bank, busA.swap_ack, busA.ram_we}, 3'b110);
    #1 checkOutput("swapReady", 32'(busA.wr_ready), 32'd1);
    tick();
    checkOutput("postSwapWrite", {busA.swap_ack, busA.ram_we, busA.ram_addr, busA.ram_wdata},
                {1'b0, 1'b1, 20'h00020, 4'h5});
    busA.wr_valid = 0;

    // A vsync edge coinciding with swap_req acceptance must not swap.
    busA.vsync = 0;
    tick();
    busA.swap_req = 1; busA.vsync = 1;
    tick();
    busA.swap_req = 0;
    checkOutput("sameCycleEdge", {busA.front_bank, busA.swap_ack}, 2'b10);
    #1 checkOutput("sameCyclePend", 32'(busA.wr_ready), 32'd0);
    tick();
    busA.vsync = 0;
    tick();
    busA.vsync = 1;
    tick();
    checkOutput("nextEdgeSwap", {busA.front_bank, busA.swap_ack}, 2'b01);
    busA.vsync = 0;

    // Instance B: reset in the middle of a clear.
    busB.swap_req = 1;
    tick();
    busB.swap_req = 0;
    tick();
    busB.vsync = 1;
    tick();
    checkOutput("clrSwapB", {busB.front_bank, busB.ram_we}, 2'b10);
    writes = 0; lastAddr = '0; lastData = '0;
    for (int i = 0; i < 30 && writes < 7; i++) begin
      tick();
      if (busB.ram_we) begin
        writes++; lastAddr = busB.ram_addr; lastData = busB.ram_wdata;
      end
    end
    checkOutput("clrSeventh", {lastAddr, lastData}, {20'h00006, 4'h9});
    rstB = 1'b1;
    tick();
    rstB = 1'b0;
    checkOutput("clrReset", {busB.front_bank, busB.ram_we, busB.swap_ack, busB.wr_ready}, 4'b0001);
    acks = 0; badWrites = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busB.swap_ack) acks++;
      if (busB.ram_we) badWrites++;
    end
    checkOutput("clrAbortQuiet", {acks[15:0], badWrites[15:0]}, 32'h0);
    busB.vsync = 0;
    tick();

    // Instance B: full clear with display interleaved every third cycle.
    busB.swap_req = 1;
    tick();
    busB.swap_req = 0;
    tick();
    busB.vsync = 1;
    tick();
    checkOutput("fullSwapB", 32'(busB.front_bank), 32'd1);
    for (int j = 0; j < 16; j++) hits[j] = 0;
    writes = 0; badWrites = 0; acks = 0; ackAtWrite = -1; ackCycle = -1;
    for (int i = 0; i < 120; i++) begin
      busB.disp_req  = (i % 3 == 0);
      busB.disp_addr = AW'(i);
      tick();
      if (busB.disp_req) checkOutput("clrDispWins", 32'(busB.ram_we), 32'd0);
      if (busB.ram_we) begin
        writes++;
        if (busB.ram_addr < 20'd16 && busB.ram_wdata == 4'h9) hits[busB.ram_addr[3:0]]++;
        else badWrites++;
      end
      if (busB.swap_ack) begin
        acks++; ackAtWrite = writes; ackCycle = i;
      end
      if (ackCycle >= 0 && i >= ackCycle + 3) break;
    end
    busB.disp_req = 0;
    checkOutput("clrAckCount", 32'(acks), 32'd1);
    checkOutput("clrAckAt16", 32'(ackAtWrite), 32'd16);
    checkOutput("clrBadWrites", 32'(badWrites), 32'd0);
    for (int j = 0; j < 16; j++) checkOutput($sformatf("clrHit%0d", j), 32'(hits[j]), 32'd1);
    busB.wr_valid = 1; busB.wr_addr = 19'h00003; busB.wr_data = 4'h2;
    #1 checkOutput("clrDoneReady", 32'(busB.wr_ready), 32'd1);
    tick();
    checkOutput("clrPostWrite", {busB.ram_we, busB.ram_addr, busB.ram_wdata, busB.front_bank},
                {1'b1, 20'h00003, 4'h2, 1'b1});
    busB.wr_valid = 0;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: LCD scan-out reads and renderer writes.
- Provides double buffering. The RAM holds two banks, selected by the address MSB. Display reads the front bank; renderer writes the back bank.
- Banks swap only on a vsync rising edge, and only after the renderer requests a swap.
- After a swap, the block can optionally clear the new back bank.
- Sits between lcd_driver's addr/data port and the framebuffer BRAM.

Parameters:
- ADDR_W, 19, per-bank pixel address width.
- DATA_W, 4, pixel (palette index) width.
- FB_WORDS, 384000, pixels per bank (800x480).
- CLEAR_EN, 1, clear the new back bank after each swap.
- CLEAR_COLOR, 4'h0, value written during clear.

Ports:
- pixel_clock  in  1  system/pixel clock
- pixel_reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read this cycle (high during active area)
- disp_addr  in  ADDR_W  display pixel address
- disp_data  out  DATA_W  read pixel
- disp_valid  out  1  disp_data valid
- wr_valid  in  1  renderer write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  renderer pixel address
- wr_data  in  DATA_W  renderer pixel
- swap_req  in  1  one-cycle pulse: back bank frame complete
- swap_ack  out  1  one-cycle pulse: swap done (and clear done if CLEAR_EN)
- front_bank  out  1  bank currently displayed
- vsync  in  1  vertical sync, active high
- ram_addr  out  ADDR_W+1  {bank, pixel address}, registered
- ram_we  out  1  write enable, registered
- ram_wdata  out  DATA_W  write data, registered
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_addr

Behaviour:
- Reset values: state=IDLE, front_bank=0, ram_addr=0, ram_we=0, ram_wdata=0, disp_data=0, disp_valid=0, swap_ack=0, clear counter=0, vsync_q=0.
- Reset is honoured in any state. Mid-clear or mid-pending, the operation is aborted and front_bank returns to 0.
- Arbitration (evaluated every cycle, priority order):
  - disp_req=1: ram_addr<={front_bank,disp_addr}, ram_we<=0. Display always wins.
  - Else state=CLEAR: clear write, see CLEAR below.
  - Else state=IDLE and wr_valid=1: ram_addr<={~front_bank,wr_addr}, ram_we<=1, ram_wdata<=wr_data.
  - Otherwise ram_we<=0 and ram_addr holds its value.
- wr_ready = !disp_req && state==IDLE (combinational). A transfer occurs when wr_valid && wr_ready.
- Display read latency is 3 cycles. A request at cycle N gives: ram_addr at N+1, ram_rdata at N+2, disp_data/disp_valid registered at N+3.
- disp_valid is disp_req delayed 3 cycles. disp_data holds its last value when disp_valid=0.
- vsync edge: vsync_q registers vsync; vsync_rise = vsync && !vsync_q.
- FSM:
  - IDLE: swap_req=1 -> PENDING. swap_req in any other state is ignored.
  - PENDING: writes stalled (wr_ready=0). On vsync_rise: front_bank toggles, then go to CLEAR if CLEAR_EN, else go to IDLE with swap_ack=1 for one cycle.
  - A vsync_rise in the same cycle swap_req is accepted does not trigger the swap; the next rising edge does.
  - CLEAR: on every cycle with disp_req=0, writes CLEAR_COLOR at {~front_bank, cnt}, then cnt++. When the write at cnt=FB_WORDS-1 issues: cnt<=0, swap_ack=1 for one cycle, next state IDLE.
  - CLEAR: vsync edges are ignored. disp_req cycles stall the counter without losing an address.
- cnt is ADDR_W bits. Addresses >= FB_WORDS are never generated.
- Out-of-range wr_addr is passed through unchecked.
- Back-bank writes never hit front_bank. Every write uses the current ~front_bank, sampled in the same cycle as the write.

Test Plan:
- Reset, then no requests for 10 cycles -> ram_we=0, front_bank=0, wr_ready=1, disp_valid=0 throughout.
- disp_req=1 with disp_addr=0x00010 while wr_valid=1 -> ram_addr=0x00010 with we=0, wr_ready=0. RAM model returns 4'hA -> disp_data=4'hA with disp_valid=1 exactly 3 cycles after the request.
- disp_req=0, wr_valid=1, wr_addr=0x12345, wr_data=4'h7 -> next cycle ram_we=1, ram_addr=0x92345 (bank 1), ram_wdata=4'h7.
- CLEAR_EN=0: swap_req pulse, then vsync rises 50 cycles later -> wr_ready=0 during the wait; front_bank becomes 1 and swap_ack pulses once on the edge cycle; subsequent writes target bank 0.
- CLEAR_EN=1, FB_WORDS=16: swap, with disp_req asserted every 3rd cycle -> addresses {0,0..15} each written once with CLEAR_COLOR; swap_ack after the 16th write; then IDLE.
- pixel_reset asserted mid-CLEAR at cnt=7 -> next cycle state IDLE, front_bank=0, ram_we=0, no swap_ack.
